// File: rtl/calc_seq_pkg.sv
// Shared encodings for the calculator input sequencer: phase codes and the
// field layout of the packed word handed to the calculator core.
package calc_seq_pkg;

   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_OP   = 2'b10,
      S_EVAL = 2'b11
   } phase_e;

   localparam int OPW_DEFAULT = 3;
   localparam int OP_W        = 2;
   localparam int A_LSB       = 0;
   localparam int B_LSB       = OPW_DEFAULT;
   localparam int OP_LSB      = 2 * OPW_DEFAULT;

endpackage

// File: rtl/calc_input_sequencer_if.sv
// Bus between the input sequencer and the calculator core / status pins.
interface calc_input_sequencer_if #(
   parameter int OPW = 3
);
   logic [2*OPW+1:0] calc_in;
   logic [7:0]       calc_out;
   logic [7:0]       result;
   logic             result_valid;
   logic [1:0]       phase;

   modport master (
      output calc_in, result, result_valid, phase,
      input  calc_out
   );

   modport slave (
      input  calc_in, result, result_valid, phase,
      output calc_out
   );
endinterface

// File: rtl/btn_sync_debounce.sv
// Pushbutton synchroniser + debouncer with a single-cycle pulse on the accepted rising edge.
module btn_sync_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   armed;
   logic                   synced;
   logic                   pending;

   assign synced = sync_q[SYNC_STAGES-1];

   // Until the button has been seen released for a full debounce window, a
   // level held through reset is not trusted and can never produce a rise.
   assign pending = armed ? (synced != level) : !synced;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt    <= '0;
         armed  <= 1'b0;
         level  <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(raw);
         rise   <= 1'b0;
         if (!pending) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE - 1)) begin
            cnt <= '0;
            if (armed) begin
               level <= synced;
               rise  <= synced;
            end else begin
               armed <= 1'b1;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/calc_input_sequencer.sv
// Operator front end for the calculator: collects A, B and opcode from switches,
// presents the packed word, waits for the core to settle and latches its result.
//
//   state  | meaning
//   S_A    | waiting for ENTER to commit operand A
//   S_B    | waiting for ENTER to commit operand B
//   S_OP   | waiting for ENTER to commit the opcode
//   S_EVAL | word presented, counting down settle time before capture
module calc_input_sequencer
   import calc_seq_pkg::*;
#(
   parameter int OPW         = 3,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 16,
   parameter int CALC_SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            btn_enter,
   input  logic            btn_clear,
   input  logic [OPW-1:0]  key_data,
   calc_input_sequencer_if.master bus
);

   logic             enter_ev;
   logic             clear_ev;
   logic             enter_level_unused;
   logic             clear_level_unused;
   logic [OPW-1:0]   key_pipe [SYNC_STAGES];
   logic [OPW-1:0]   key_s;

   phase_e           state;
   logic [OPW-1:0]   a_q;
   logic [OPW-1:0]   b_q;
   logic [OP_W-1:0]  op_q;
   logic [7:0]       settle_cnt;
   logic [7:0]       result_q;
   logic             valid_q;
   logic [2*OPW+1:0] calc_in_q;

   btn_sync_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE)
   ) u_enter (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_enter),
      .level (enter_level_unused),
      .rise  (enter_ev)
   );

   btn_sync_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE)
   ) u_clear (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_clear),
      .level (clear_level_unused),
      .rise  (clear_ev)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) key_pipe[i] <= '0;
      end else begin
         key_pipe[0] <= key_data;
         for (int i = 1; i < SYNC_STAGES; i++) key_pipe[i] <= key_pipe[i-1];
      end
   end

   assign key_s = key_pipe[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_A;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         settle_cnt <= '0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         calc_in_q  <= '0;
      end else begin
         calc_in_q <= {op_q, b_q, a_q};
         // Events seen while disabled are simply lost; the debouncers keep running.
         if (ena) begin
            if (clear_ev) begin
               state      <= S_A;
               a_q        <= '0;
               b_q        <= '0;
               op_q       <= '0;
               settle_cnt <= '0;
               result_q   <= '0;
               valid_q    <= 1'b0;
            end else begin
               unique case (state)
                  S_A: if (enter_ev) begin
                     a_q     <= key_s;
                     valid_q <= 1'b0;
                     state   <= S_B;
                  end
                  S_B: if (enter_ev) begin
                     b_q   <= key_s;
                     state <= S_OP;
                  end
                  S_OP: if (enter_ev) begin
                     op_q       <= key_s[OP_W-1:0];
                     settle_cnt <= 8'(CALC_SETTLE);
                     state      <= S_EVAL;
                  end
                  S_EVAL: begin
                     if (settle_cnt == 8'd0) begin
                        result_q <= bus.calc_out;
                        valid_q  <= 1'b1;
                        state    <= S_A;
                     end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                     end
                  end
               endcase
            end
         end
      end
   end

   assign bus.calc_in      = calc_in_q;
   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
   assign bus.phase        = state;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed + randomized bench for calc_input_sequencer against a transaction-level model.
module tb_calc_input_sequencer;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       ena       = 1'b0;
   logic       btn_enter = 1'b0;
   logic       btn_clear = 1'b0;
   logic [2:0] key_data  = 3'd0;

   int n_pass  = 0;
   int n_total = 0;

   int m_a, m_b, m_op, m_phase, m_result, m_valid;

   calc_input_sequencer_if #(.OPW(3)) bus();

   function automatic logic [7:0] calc_fn(input logic [2:0] a, input logic [2:0] b,
                                          input logic [1:0] op);
      int ia, ib, s;
      ia = int'(a);
      ib = int'(b);
      case (op)
         2'd0:    s = ia + ib;
         2'd1:    s = ia - ib;
         2'd2:    s = ia * ib;
         default: s = ia ^ ib;
      endcase
      return 8'(s);
   endfunction

   assign bus.calc_out = calc_fn(bus.calc_in[2:0], bus.calc_in[5:3], bus.calc_in[7:6]);

   calc_input_sequencer #(
      .OPW         (3),
      .SYNC_STAGES (2),
      .DEBOUNCE    (4),
      .CALC_SETTLE (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .btn_enter (btn_enter),
      .btn_clear (btn_clear),
      .key_data  (key_data),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int exp_word();
      return m_op * 64 + m_b * 8 + m_a;
   endfunction

   task automatic model_reset();
      m_a = 0; m_b = 0; m_op = 0; m_phase = 0; m_result = 0; m_valid = 0;
   endtask

   task automatic model_enter(input int key);
      case (m_phase)
         0: begin m_a = key; m_valid = 0; m_phase = 1; end
         1: begin m_b = key; m_phase = 2; end
         2: begin m_op = key % 4; m_phase = 3; end
         default: ;
      endcase
   endtask

   task automatic model_capture();
      m_result = int'(calc_fn(3'(m_a), 3'(m_b), 2'(m_op)));
      m_valid  = 1;
      m_phase  = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".phase"},   32'(bus.phase),        32'(m_phase));
      check({tag, ".calc_in"}, 32'(bus.calc_in),      32'(exp_word()));
      check({tag, ".result"},  32'(bus.result),       32'(m_result));
      check({tag, ".valid"},   32'(bus.result_valid), 32'(m_valid));
   endtask

   task automatic press(input int key);
      key_data = 3'(key);
      tick(2);
      btn_enter = 1'b1;
      tick(8);
      btn_enter = 1'b0;
      tick(10);
      model_enter(key);
      if (m_phase == 3) model_capture();
   endtask

   initial begin
      int va, vb, vop, waited;
      model_reset();

      // Reset state
      #2;
      check_all("reset");
      tick(2);
      rst_n = 1'b1;
      ena   = 1'b1;
      tick(10);
      check_all("post_reset");

      // Directed 3 + 5 with op 00, exact settle latency
      press(3);
      check("t1.phase_b", 32'(bus.phase), 32'd1);
      press(5);
      check("t1.phase_op", 32'(bus.phase), 32'd2);
      key_data = 3'd0;
      tick(2);
      btn_enter = 1'b1;
      waited = 0;
      while (bus.phase != 2'b11 && waited < 20) begin
         tick(1);
         waited++;
      end
      check("t1.reach_eval", 32'(bus.phase), 32'd3);
      tick(1);
      check("t1.calc_in", 32'(bus.calc_in), 32'h2B);
      check("t1.valid_settling", 32'(bus.result_valid), 32'd0);
      tick(1);
      check("t1.valid_settling2", 32'(bus.result_valid), 32'd0);
      tick(1);
      check("t1.result", 32'(bus.result), 32'h08);
      check("t1.valid", 32'(bus.result_valid), 32'd1);
      check("t1.phase_a", 32'(bus.phase), 32'd0);
      tick(6);
      btn_enter = 1'b0;
      tick(10);
      model_enter(0);
      model_capture();
      check_all("t1.final");

      // Glitch shorter than debounce, then a minimal valid press
      key_data = 3'd7;
      tick(2);
      btn_enter = 1'b1;
      tick(3);
      btn_enter = 1'b0;
      tick(10);
      check_all("t2.glitch");
      btn_enter = 1'b1;
      tick(6);
      btn_enter = 1'b0;
      tick(10);
      model_enter(7);
      check_all("t2.press6");

      // Randomized operand/opcode sequences
      vb  = int'($urandom_range(0, 7));
      vop = int'($urandom_range(0, 7));
      press(vb);
      press(vop);
      check_all("rand.first");
      for (int i = 0; i < 6; i++) begin
         va  = int'($urandom_range(0, 7));
         vb  = int'($urandom_range(0, 7));
         vop = int'($urandom_range(0, 7));
         press(va);
         press(vb);
         press(vop);
         check_all($sformatf("rand%0d", i));
      end

      // ENTER arriving during S_EVAL is dropped
      press(1);
      press(2);
      key_data = 3'd1;
      tick(2);
      btn_enter = 1'b1;
      waited = 0;
      while (bus.phase != 2'b11 && waited < 20) begin
         tick(1);
         waited++;
      end
      ena = 1'b0;
      model_enter(1);
      tick(1);
      check_all("t3.frozen_eval");
      btn_enter = 1'b0;
      tick(10);
      check("t3.still_eval", 32'(bus.phase), 32'd3);
      btn_enter = 1'b1;
      tick(5);
      ena = 1'b1;
      tick(10);
      btn_enter = 1'b0;
      tick(10);
      model_capture();
      check_all("t3.after_eval");

      // CLEAR and ENTER together in S_B
      press(6);
      check("t4.in_b", 32'(bus.phase), 32'd1);
      btn_enter = 1'b1;
      btn_clear = 1'b1;
      tick(8);
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      tick(10);
      model_reset();
      check_all("t4.clear");

      // ena low during a press in S_A
      ena = 1'b0;
      key_data = 3'd4;
      tick(2);
      btn_enter = 1'b1;
      tick(12);
      check("t6.disabled", 32'(bus.phase), 32'd0);
      ena = 1'b1;
      tick(10);
      check("t6.enabled_held", 32'(bus.phase), 32'd0);
      btn_enter = 1'b0;
      tick(10);
      press(4);
      check_all("t6.fresh_press");

      // Reset asserted in S_OP with ENTER held through release
      press(5);
      check("t5.in_op", 32'(bus.phase), 32'd2);
      btn_enter = 1'b1;
      tick(3);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("t5.async_reset");
      tick(2);
      rst_n = 1'b1;
      tick(20);
      check("t5.held_no_event", 32'(bus.phase), 32'd0);
      btn_enter = 1'b0;
      tick(10);
      press(6);
      check_all("t5.repress");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
